// File: rtl/hashmap_req_ctrl_pkg.sv
// Shared types for the cuckoo hashmap request controller: the request opcode encoding.
package hashmap_req_ctrl_pkg;

    typedef enum logic [1:0] {
        OpLookup = 2'd0,
        OpUpdate = 2'd1,
        OpDelete = 2'd2,
        OpInsert = 2'd3
    } op_t;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_UPDATE = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_INSERT = 2'd3;

endpackage

// File: rtl/hashmap_req_ctrl_ins_fifo.sv
// Pending-insert FIFO holding {key, value} pairs that missed the table.
// Exposes per-entry key/valid taps so the controller can block same-key requests.
module hashmap_req_ctrl_ins_fifo #(
    parameter int unsigned KeyBits = 8,
    parameter int unsigned ValBits = 8,
    parameter int unsigned Depth   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push_i,
    input  logic [KeyBits-1:0]              push_key_i,
    input  logic [ValBits-1:0]              push_value_i,
    input  logic                            pop_i,
    output logic                            empty_o,
    output logic [KeyBits-1:0]              head_key_o,
    output logic [ValBits-1:0]              head_value_o,
    output logic [$clog2(Depth):0]          count_o,
    output logic [Depth-1:0]                entry_valid_o,
    output logic [Depth-1:0][KeyBits-1:0]   entry_key_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]                count_q, count_d;
    logic [Depth-1:0]             valid_q, valid_d;
    logic [Depth-1:0][KeyBits-1:0] key_q;
    logic [Depth-1:0][ValBits-1:0] value_q;
    logic                         do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // Full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != FullCount) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (do_pop) begin
            rd_ptr_d          = rd_ptr_q + 1'b1;
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (do_push) begin
            wr_ptr_d          = wr_ptr_q + 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            value_q <= '0;
        end else if (do_push) begin
            key_q[wr_ptr_q]   <= push_key_i;
            value_q[wr_ptr_q] <= push_value_i;
        end
    end

    assign empty_o       = (count_q == '0);
    assign head_key_o    = key_q[rd_ptr_q];
    assign head_value_o  = value_q[rd_ptr_q];
    assign count_o       = count_q;
    assign entry_valid_o = valid_q;
    assign entry_key_o   = key_q;

endmodule

// File: rtl/hashmap_req_ctrl.sv
// Request-side controller for a cuckoo table: lookup, delayed writeback and insert draining.
// Optional HASHMAP_REQ_STATS_EN adds saturating hit/miss/insert counters.
module hashmap_req_ctrl
    import hashmap_req_ctrl_pkg::*;
#(
    parameter int unsigned NumKeyBits   = 8,
    parameter int unsigned NumValBits   = 8,
    parameter int unsigned NumPipes     = 1,
    parameter int unsigned InsFifoDepth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [NumKeyBits-1:0] req_key_i,
    input  logic [NumValBits-1:0] req_value_i,
    output logic                  lookup_o,
    output logic [NumKeyBits-1:0] lu_key_o,
    output logic                  modify_o,
    output logic                  del_o,
    output logic [NumValBits-1:0] mod_value_o,
    input  logic                  tbl_hit_i,
    input  logic [NumValBits-1:0] tbl_value_i,
    input  logic                  tbl_busy_i,
    output logic                  ins_valid_o,
    output logic [NumKeyBits-1:0] ins_key_o,
    output logic [NumValBits-1:0] ins_value_o,
    output logic                  rsp_valid_o,
    output logic [1:0]            rsp_op_o,
    output logic                  rsp_hit_o,
    output logic [NumValBits-1:0] rsp_value_o
`ifdef HASHMAP_REQ_STATS_EN
    ,
    output logic [31:0]           stat_hits_o,
    output logic [31:0]           stat_misses_o,
    output logic [31:0]           stat_inserts_o
`endif
);

    localparam int unsigned Last = NumPipes - 1;
    localparam int unsigned CntW = $clog2(InsFifoDepth) + 1;

    op_t                   req_op;
    logic                  accept;
    logic                  key_hazard;
    logic                  ins_full;
    logic [31:0]           inflight_ins;

    logic [NumPipes-1:0]   pipe_valid_q;
    op_t                   pipe_op_q    [NumPipes];
    logic [NumKeyBits-1:0] pipe_key_q   [NumPipes];
    logic [NumValBits-1:0] pipe_value_q [NumPipes];

    logic                  tail_valid, tail_hit;
    op_t                   tail_op;

    logic                                   fifo_push, fifo_empty;
    logic [CntW-1:0]                        fifo_count;
    logic [InsFifoDepth-1:0]                fifo_entry_valid;
    logic [InsFifoDepth-1:0][NumKeyBits-1:0] fifo_entry_key;

    logic                  rsp_valid_q, rsp_hit_q;
    logic [1:0]            rsp_op_q;
    logic [NumValBits-1:0] rsp_value_q;

    assign req_op = op_t'(req_op_i);

    // A request whose key is still pending insertion would see a stale miss or insert twice.
    always_comb begin
        key_hazard   = 1'b0;
        inflight_ins = '0;
        for (int i = 0; i < InsFifoDepth; i++) begin
            if (fifo_entry_valid[i] && (fifo_entry_key[i] == req_key_i)) key_hazard = 1'b1;
        end
        for (int i = 0; i < NumPipes; i++) begin
            if (pipe_valid_q[i] && (pipe_op_q[i] == OpInsert)) begin
                inflight_ins = inflight_ins + 32'd1;
                if (pipe_key_q[i] == req_key_i) key_hazard = 1'b1;
            end
        end
    end

    // Every in-flight INSERT may miss, so reserve a FIFO slot for each.
    assign ins_full    = (32'(fifo_count) + inflight_ins) >= InsFifoDepth;
    assign req_ready_o = rst_n && !key_hazard && !((req_op == OpInsert) && ins_full);
    assign accept      = req_valid_i && req_ready_o;
    assign lookup_o    = accept;
    assign lu_key_o    = req_key_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < NumPipes; i++) begin
                pipe_op_q[i]    <= OpLookup;
                pipe_key_q[i]   <= '0;
                pipe_value_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_op_q[0]    <= req_op;
            pipe_key_q[0]   <= req_key_i;
            pipe_value_q[0] <= req_value_i;
            for (int i = 1; i < NumPipes; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_op_q[i]    <= pipe_op_q[i-1];
                pipe_key_q[i]   <= pipe_key_q[i-1];
                pipe_value_q[i] <= pipe_value_q[i-1];
            end
        end
    end

    assign tail_valid  = pipe_valid_q[Last];
    assign tail_op     = pipe_op_q[Last];
    assign tail_hit    = tail_valid && tbl_hit_i;
    assign modify_o    = tail_hit && (tail_op != OpLookup);
    assign del_o       = tail_hit && (tail_op == OpDelete);
    assign mod_value_o = pipe_value_q[Last];
    assign fifo_push   = tail_valid && !tbl_hit_i && (tail_op == OpInsert);

    // Column lookups win over drained inserts on the shared first column.
    assign ins_valid_o = !fifo_empty && !lookup_o && !tbl_busy_i;

    hashmap_req_ctrl_ins_fifo #(
        .KeyBits (NumKeyBits),
        .ValBits (NumValBits),
        .Depth   (InsFifoDepth)
    ) u_ins_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (fifo_push),
        .push_key_i    (pipe_key_q[Last]),
        .push_value_i  (pipe_value_q[Last]),
        .pop_i         (ins_valid_o),
        .empty_o       (fifo_empty),
        .head_key_o    (ins_key_o),
        .head_value_o  (ins_value_o),
        .count_o       (fifo_count),
        .entry_valid_o (fifo_entry_valid),
        .entry_key_o   (fifo_entry_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= 2'd0;
            rsp_hit_q   <= 1'b0;
            rsp_value_q <= '0;
        end else begin
            rsp_valid_q <= tail_valid;
            rsp_op_q    <= tail_op;
            rsp_hit_q   <= tail_hit;
            rsp_value_q <= tail_hit ? tbl_value_i : '0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_op_o    = rsp_op_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_value_o = rsp_value_q;

`ifdef HASHMAP_REQ_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q, stat_inserts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_q    <= '0;
            stat_misses_q  <= '0;
            stat_inserts_q <= '0;
        end else begin
            if (rsp_valid_q && rsp_hit_q && (stat_hits_q != '1)) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (rsp_valid_q && !rsp_hit_q && (stat_misses_q != '1)) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
            if (ins_valid_o && (stat_inserts_q != '1)) begin
                stat_inserts_q <= stat_inserts_q + 32'd1;
            end
        end
    end

    assign stat_hits_o    = stat_hits_q;
    assign stat_misses_o  = stat_misses_q;
    assign stat_inserts_o = stat_inserts_q;
`endif

endmodule
